// File: rtl/imp_csr_axil_slave.sv
// AXI4-Lite CSR block for the IMP read/write masters: config registers,
// start pulse, busy/done status and a level interrupt.
module imp_csr_axil_slave #(
  parameter logic [31:0] ID_VALUE   = 32'h494D_5001,
  parameter int unsigned ADDR_LSB_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_aw_valid,
  output logic        s_aw_ready,
  input  logic [31:0] s_aw_addr,
  input  logic [2:0]  s_aw_prot,
  input  logic        s_w_valid,
  output logic        s_w_ready,
  input  logic [31:0] s_w_data,
  input  logic [3:0]  s_w_strb,
  output logic        s_b_valid,
  input  logic        s_b_ready,
  output logic [1:0]  s_b_resp,
  input  logic        s_ar_valid,
  output logic        s_ar_ready,
  input  logic [31:0] s_ar_addr,
  output logic        s_r_valid,
  input  logic        s_r_ready,
  output logic [31:0] s_r_data,
  output logic [1:0]  s_r_resp,
  input  logic        imp_done,
  output logic        imp_start,
  output logic [7:0]  imp_hsize,
  output logic [7:0]  imp_vsize,
  output logic [7:0]  imp_minx,
  output logic [7:0]  imp_miny,
  output logic [7:0]  imp_pitch,
  output logic [31:0] imp_src_baddr,
  output logic [31:0] imp_dst_baddr,
  output logic        imp_busy,
  output logic        irq
);

  typedef enum logic [3:0] {
    REG_CTRL   = 4'd0,
    REG_STATUS = 4'd1,
    REG_HSIZE  = 4'd2,
    REG_VSIZE  = 4'd3,
    REG_MINX   = 4'd4,
    REG_MINY   = 4'd5,
    REG_SRC    = 4'd6,
    REG_DST    = 4'd7,
    REG_PITCH  = 4'd8,
    REG_ID     = 4'd9
  } reg_idx_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Offsets 0x00..0x27 inside the decoded window; upper address bits alias.
  function automatic logic addr_hit(input logic [31:0] a);
    return (a[ADDR_LSB_W-1:6] == '0) && (a[5:2] <= REG_ID);
  endfunction

  logic        rdy_en_q,  rdy_en_d;
  logic        aw_held_q, aw_held_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic        w_held_q,  w_held_d;
  logic [31:0] w_data_q,  w_data_d;
  logic [3:0]  w_strb_q,  w_strb_d;
  logic        b_valid_q, b_valid_d;
  logic [1:0]  b_resp_q,  b_resp_d;
  logic        r_valid_q, r_valid_d;
  logic [31:0] r_data_q,  r_data_d;
  logic [1:0]  r_resp_q,  r_resp_d;
  logic        irq_en_q,  irq_en_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;
  logic        start_q,   start_d;
  logic        irq_q,     irq_d;
  logic [7:0]  hsize_q, hsize_d, vsize_q, vsize_d;
  logic [7:0]  minx_q, minx_d, miny_q, miny_d, pitch_q, pitch_d;
  logic [31:0] src_q, src_d, dst_q, dst_d;

  logic        aw_hs, w_hs, ar_hs, commit, w_hit, start_req, done_clr;
  logic [31:0] wa, wd, rdata;
  logic [3:0]  ws;
  logic        r_err;
  logic        unused_ok;

  assign s_aw_ready = rdy_en_q & ~aw_held_q & ~b_valid_q;
  assign s_w_ready  = rdy_en_q & ~w_held_q & ~b_valid_q;
  assign s_ar_ready = rdy_en_q & ~r_valid_q;
  assign aw_hs      = s_aw_valid & s_aw_ready;
  assign w_hs       = s_w_valid & s_w_ready;
  assign ar_hs      = s_ar_valid & s_ar_ready;

  // A handshake in the current cycle bypasses the holding register so the
  // commit lands on the same edge as the last of AW/W.
  assign wa     = aw_held_q ? aw_addr_q : s_aw_addr;
  assign wd     = w_held_q  ? w_data_q  : s_w_data;
  assign ws     = w_held_q  ? w_strb_q  : s_w_strb;
  assign commit = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~b_valid_q;
  assign w_hit  = addr_hit(wa);

  assign unused_ok = ^{s_aw_prot, wa[31:ADDR_LSB_W], wa[1:0],
                       s_ar_addr[31:ADDR_LSB_W], s_ar_addr[1:0]};

  assign s_b_valid     = b_valid_q;
  assign s_b_resp      = b_resp_q;
  assign s_r_valid     = r_valid_q;
  assign s_r_data      = r_data_q;
  assign s_r_resp      = r_resp_q;
  assign imp_start     = start_q;
  assign imp_busy      = busy_q;
  assign irq           = irq_q;
  assign imp_hsize     = hsize_q;
  assign imp_vsize     = vsize_q;
  assign imp_minx      = minx_q;
  assign imp_miny      = miny_q;
  assign imp_pitch     = pitch_q;
  assign imp_src_baddr = src_q;
  assign imp_dst_baddr = dst_q;

  // Read mux over the current (pre-commit) register values.
  always_comb begin
    rdata = '0;
    r_err = 1'b0;
    if (!addr_hit(s_ar_addr)) begin
      r_err = 1'b1;
    end else begin
      case (s_ar_addr[5:2])
        REG_CTRL:   rdata = {30'b0, irq_en_q, 1'b0};
        REG_STATUS: rdata = {30'b0, done_q, busy_q};
        REG_HSIZE:  rdata = {24'b0, hsize_q};
        REG_VSIZE:  rdata = {24'b0, vsize_q};
        REG_MINX:   rdata = {24'b0, minx_q};
        REG_MINY:   rdata = {24'b0, miny_q};
        REG_SRC:    rdata = src_q;
        REG_DST:    rdata = dst_q;
        REG_PITCH:  rdata = {24'b0, pitch_q};
        REG_ID:     rdata = ID_VALUE;
        default:    r_err = 1'b1;
      endcase
    end
  end

  // Channel handshakes, register writes and busy/done/irq bookkeeping.
  always_comb begin
    rdy_en_d  = 1'b1;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_hs ? s_aw_addr : aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_hs ? s_w_data : w_data_q;
    w_strb_d  = w_hs ? s_w_strb : w_strb_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    irq_en_d  = irq_en_q;
    hsize_d   = hsize_q;
    vsize_d   = vsize_q;
    minx_d    = minx_q;
    miny_d    = miny_q;
    pitch_d   = pitch_q;
    src_d     = src_q;
    dst_d     = dst_q;
    start_req = 1'b0;
    done_clr  = 1'b0;

    if (aw_hs) aw_held_d = 1'b1;
    if (w_hs)  w_held_d  = 1'b1;

    if (b_valid_q && s_b_ready) b_valid_d = 1'b0;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      b_valid_d = 1'b1;
      b_resp_d  = w_hit ? RESP_OKAY : RESP_SLVERR;
      if (w_hit) begin
        case (wa[5:2])
          REG_CTRL: if (ws[0]) begin
            irq_en_d  = wd[1];
            start_req = wd[0];
          end
          REG_STATUS: if (ws[0] && wd[1]) done_clr = 1'b1;
          REG_HSIZE:  if (ws[0]) hsize_d = wd[7:0];
          REG_VSIZE:  if (ws[0]) vsize_d = wd[7:0];
          REG_MINX:   if (ws[0]) minx_d  = wd[7:0];
          REG_MINY:   if (ws[0]) miny_d  = wd[7:0];
          REG_PITCH:  if (ws[0]) pitch_d = wd[7:0];
          REG_SRC:
            for (int unsigned i = 0; i < 4; i++)
              if (ws[i]) src_d[8*i +: 8] = wd[8*i +: 8];
          REG_DST:
            for (int unsigned i = 0; i < 4; i++)
              if (ws[i]) dst_d[8*i +: 8] = wd[8*i +: 8];
          default: ;
        endcase
      end
    end

    if (r_valid_q && s_r_ready) r_valid_d = 1'b0;
    if (ar_hs) begin
      r_valid_d = 1'b1;
      r_data_d  = rdata;
      r_resp_d  = r_err ? RESP_SLVERR : RESP_OKAY;
    end

    // Start beats a same-cycle done for BUSY; done beats W1C for DONE.
    start_d = start_req & ~busy_q;
    if (start_d)       busy_d = 1'b1;
    else if (imp_done) busy_d = 1'b0;
    else               busy_d = busy_q;
    if (imp_done)      done_d = 1'b1;
    else if (done_clr) done_d = 1'b0;
    else               done_d = done_q;
    irq_d = done_q & irq_en_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_en_q  <= 1'b0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      irq_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
      hsize_q   <= '0;
      vsize_q   <= '0;
      minx_q    <= '0;
      miny_q    <= '0;
      pitch_q   <= '0;
      src_q     <= '0;
      dst_q     <= '0;
    end else begin
      rdy_en_q  <= rdy_en_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      irq_en_q  <= irq_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start_d;
      irq_q     <= irq_d;
      hsize_q   <= hsize_d;
      vsize_q   <= vsize_d;
      minx_q    <= minx_d;
      miny_q    <= miny_d;
      pitch_q   <= pitch_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
    end
  end

endmodule

// File: tb/tb_imp_csr_axil_slave.sv
// Directed self-checking bench for imp_csr_axil_slave.
module tb_imp_csr_axil_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_aw_valid, s_aw_ready;
  logic [31:0] s_aw_addr;
  logic [2:0]  s_aw_prot;
  logic        s_w_valid, s_w_ready;
  logic [31:0] s_w_data;
  logic [3:0]  s_w_strb;
  logic        s_b_valid, s_b_ready;
  logic [1:0]  s_b_resp;
  logic        s_ar_valid, s_ar_ready;
  logic [31:0] s_ar_addr;
  logic        s_r_valid, s_r_ready;
  logic [31:0] s_r_data;
  logic [1:0]  s_r_resp;
  logic        imp_done, imp_start, imp_busy, irq;
  logic [7:0]  imp_hsize, imp_vsize, imp_minx, imp_miny, imp_pitch;
  logic [31:0] imp_src_baddr, imp_dst_baddr;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;

  imp_csr_axil_slave #(.ID_VALUE(32'h494D_5001), .ADDR_LSB_W(12)) dut (
    .clk(clk), .rst(rst),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr),
    .s_aw_prot(s_aw_prot),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
    .s_w_strb(s_w_strb),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp),
    .imp_done(imp_done), .imp_start(imp_start),
    .imp_hsize(imp_hsize), .imp_vsize(imp_vsize), .imp_minx(imp_minx),
    .imp_miny(imp_miny), .imp_pitch(imp_pitch),
    .imp_src_baddr(imp_src_baddr), .imp_dst_baddr(imp_dst_baddr),
    .imp_busy(imp_busy), .irq(irq)
  );

  always #5 clk = ~clk;

  // Counts cycles with imp_start high, so a stretched pulse shows up.
  always @(posedge clk) if (imp_start === 1'b1) start_cnt <= start_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int unsigned n;
    logic aw_done, w_done;
    s_aw_addr = addr; s_w_data = data; s_w_strb = strb;
    s_aw_valid = 1'b1; s_w_valid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      if (s_aw_valid && s_aw_ready) aw_done = 1'b1;
      if (s_w_valid && s_w_ready)   w_done  = 1'b1;
      tick(); n++;
      if (aw_done) s_aw_valid = 1'b0;
      if (w_done)  s_w_valid  = 1'b0;
    end
    n = 0;
    while (!s_b_valid && n < 20) begin tick(); n++; end
    check_eq("b_wait", {31'b0, s_b_valid}, 32'd1);
    resp = s_b_resp;
    s_b_ready = 1'b1;
    tick();
    s_b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int unsigned n;
    s_ar_addr = addr; s_ar_valid = 1'b1; n = 0;
    while (!s_ar_ready && n < 20) begin tick(); n++; end
    tick();
    s_ar_valid = 1'b0;
    check_eq("r_valid", {31'b0, s_r_valid}, 32'd1);
    data = s_r_data; resp = s_r_resp;
    s_r_ready = 1'b1;
    tick();
    s_r_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rsp;

  initial begin
    rst = 1'b1;
    s_aw_valid = 0; s_aw_addr = '0; s_aw_prot = '0;
    s_w_valid = 0; s_w_data = '0; s_w_strb = '0;
    s_b_ready = 0; s_ar_valid = 0; s_ar_addr = '0; s_r_ready = 0;
    imp_done = 0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_aw_ready", {31'b0, s_aw_ready}, 32'd0);
    check_eq("rst_ar_ready", {31'b0, s_ar_ready}, 32'd0);
    check_eq("rst_b_valid",  {31'b0, s_b_valid}, 32'd0);
    check_eq("rst_r_valid",  {31'b0, s_r_valid}, 32'd0);
    check_eq("rst_r_data",   s_r_data, 32'd0);
    check_eq("rst_busy_irq", {30'b0, imp_busy, irq}, 32'd0);
    check_eq("rst_hsize",    {24'b0, imp_hsize}, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_ready", {29'b0, s_aw_ready, s_w_ready, s_ar_ready}, 32'h7);

    // ID and STATUS after reset
    axi_read(32'h24, rd, rsp);
    check_eq("id_data", rd, 32'h494D_5001);
    check_eq("id_resp", {30'b0, rsp}, 32'd0);
    axi_read(32'h04, rd, rsp);
    check_eq("status_rst", rd, 32'd0);
    axi_read(32'h1024, rd, rsp);
    check_eq("id_alias", rd, 32'h494D_5001);

    // Byte strobes on SRC_BADDR
    axi_write(32'h18, 32'hAABBCCDD, 4'b0101, rsp);
    check_eq("src_resp", {30'b0, rsp}, 32'd0);
    check_eq("src_out", imp_src_baddr, 32'h00BB00DD);
    axi_read(32'h18, rd, rsp);
    check_eq("src_rd", rd, 32'h00BB00DD);

    // W two cycles ahead of AW, then B backpressure
    s_w_data = 32'h0000_0004; s_w_strb = 4'b0001; s_w_valid = 1'b1;
    tick();
    s_w_valid = 1'b0;
    check_eq("w_held_ready", {31'b0, s_w_ready}, 32'd0);
    tick();
    s_aw_addr = 32'h08; s_aw_valid = 1'b1;
    tick();
    s_aw_valid = 1'b0;
    check_eq("b_after_aw", {31'b0, s_b_valid}, 32'd1);
    check_eq("b_resp_hsize", {30'b0, s_b_resp}, 32'd0);
    check_eq("hsize_out", {24'b0, imp_hsize}, 32'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("b_hold", {29'b0, s_b_valid, s_aw_ready, s_w_ready}, 32'h4);
    end
    s_b_ready = 1'b1;
    tick();
    s_b_ready = 1'b0;
    check_eq("b_release", {30'b0, s_b_valid, s_aw_ready}, 32'h1);
    axi_read(32'h08, rd, rsp);
    check_eq("hsize_rd", rd, 32'd4);

    // START / BUSY / DONE / IRQ
    axi_write(32'h00, 32'h3, 4'hF, rsp);
    check_eq("start_pulses", start_cnt, 32'd1);
    check_eq("busy_set", {31'b0, imp_busy}, 32'd1);
    axi_read(32'h00, rd, rsp);
    check_eq("ctrl_rd", rd, 32'h2);
    axi_write(32'h00, 32'h3, 4'hF, rsp);
    tick();
    check_eq("start_dropped", start_cnt, 32'd1);
    check_eq("start_drop_resp", {30'b0, rsp}, 32'd0);
    imp_done = 1'b1;
    tick();
    imp_done = 1'b0;
    check_eq("busy_clr", {31'b0, imp_busy}, 32'd0);
    tick();
    check_eq("irq_set", {31'b0, irq}, 32'd1);
    axi_read(32'h04, rd, rsp);
    check_eq("status_done", rd, 32'h2);
    axi_write(32'h04, 32'h2, 4'hF, rsp);
    check_eq("irq_clr", {31'b0, irq}, 32'd0);
    axi_read(32'h04, rd, rsp);
    check_eq("status_w1c", rd, 32'h0);

    // W1C colliding with imp_done: done wins
    s_aw_addr = 32'h04; s_w_data = 32'h2; s_w_strb = 4'hF;
    s_aw_valid = 1'b1; s_w_valid = 1'b1; imp_done = 1'b1;
    tick();
    s_aw_valid = 1'b0; s_w_valid = 1'b0; imp_done = 1'b0;
    s_b_ready = 1'b1;
    tick();
    s_b_ready = 1'b0;
    axi_read(32'h04, rd, rsp);
    check_eq("w1c_vs_done", rd, 32'h2);

    // START accepted together with imp_done: BUSY=1, DONE=1
    axi_write(32'h04, 32'h2, 4'hF, rsp);
    s_aw_addr = 32'h00; s_w_data = 32'h1; s_w_strb = 4'hF;
    s_aw_valid = 1'b1; s_w_valid = 1'b1; imp_done = 1'b1;
    tick();
    s_aw_valid = 1'b0; s_w_valid = 1'b0; imp_done = 1'b0;
    s_b_ready = 1'b1;
    tick();
    s_b_ready = 1'b0;
    check_eq("start_with_done", start_cnt, 32'd2);
    axi_read(32'h04, rd, rsp);
    check_eq("status_both", rd, 32'h3);
    imp_done = 1'b1;
    tick();
    imp_done = 1'b0;

    // Unmapped offsets
    axi_read(32'h30, rd, rsp);
    check_eq("err_rd_data", rd, 32'd0);
    check_eq("err_rd_resp", {30'b0, rsp}, 32'h2);
    axi_read(32'h124, rd, rsp);
    check_eq("err_rd_hi_resp", {30'b0, rsp}, 32'h2);
    axi_write(32'h2C, 32'hFFFF_FFFF, 4'hF, rsp);
    check_eq("err_wr_resp", {30'b0, rsp}, 32'h2);
    check_eq("err_no_hsize", {24'b0, imp_hsize}, 32'd4);
    check_eq("err_no_src", imp_src_baddr, 32'h00BB00DD);
    check_eq("err_no_start", start_cnt, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imp_csr_axil_slave.md
# imp_csr_axil_slave

AXI4-Lite responder holding the configuration and status registers of the image-move (IMP) read/write masters. The CPU reaches it as one crossbar slave port. It accepts single-beat reads and writes and drives the IMP config buses, a one-cycle start pulse and a level interrupt. It collects the IMP done pulse into a sticky status bit.

## Interface
- ID_VALUE, 32'h494D_5001, constant returned at offset 0x24.
- ADDR_LSB_W, 12, number of low address bits decoded; higher bits are ignored and the region aliases.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_aw_valid / s_aw_ready  in / out  1  write-address handshake.
- s_aw_addr  in  32  write address.
- s_aw_prot  in  3  ignored.
- s_w_valid / s_w_ready  in / out  1  write-data handshake.
- s_w_data  in  32  write data.
- s_w_strb  in  4  byte strobes.
- s_b_valid / s_b_ready  out / in  1  write-response handshake.
- s_b_resp  out  2  write response.
- s_ar_valid / s_ar_ready  in / out  1  read-address handshake.
- s_ar_addr  in  32  read address.
- s_r_valid / s_r_ready  out / in  1  read-data handshake.
- s_r_data  out  32  read data.
- s_r_resp  out  2  read response.
- imp_done  in  1  one-cycle completion pulse from the IMP masters.
- imp_start  out  1  one-cycle start pulse.
- imp_hsize, imp_vsize, imp_minx, imp_miny, imp_pitch  out  8 each  configuration values.
- imp_src_baddr, imp_dst_baddr  out  32 each  base addresses.
- imp_busy  out  1  the IMP masters are running.
- irq  out  1  equals DONE & IRQ_EN.

## Operation
Register map, decoded on addr[5:2] within the ADDR_LSB_W window:
- 0x00 CTRL: bit0 START, bit1 IRQ_EN.
  - Writing START=1 pulses imp_start. START reads back as 0.
  - If BUSY=1, the START request is dropped and the write still returns OKAY.
- 0x04 STATUS: bit0 BUSY is read-only. bit1 DONE is sticky and cleared by writing 1 (W1C).
- 0x08 HSIZE[7:0], 0x0C VSIZE[7:0], 0x10 MINX[7:0], 0x14 MINY[7:0], 0x20 PITCH[7:0]: read/write.
  - Only strobe bit 0 matters. The upper bytes read as 0.
- 0x18 SRC_BADDR, 0x1C DST_BADDR: 32-bit read/write. Each byte is updated only when its strobe bit is set.
- 0x24 ID: read-only, returns ID_VALUE.
- Writes to 0x04 bit0 or to 0x24 are ignored and return OKAY.
- Any other offset, or any offset at or above 0x28:
  - Reads return data 0 with resp 2'b10 (SLVERR).
  - Writes change nothing and return SLVERR.
- BUSY is set when imp_start is pulsed. BUSY is cleared, and DONE set, on imp_done.
  - imp_done while BUSY=0 still sets DONE.
  - imp_done in the same cycle as a DONE W1C: the set wins and DONE stays 1.
  - imp_done in the same cycle as an accepted START: BUSY ends 1, DONE ends 1.

Write path:
- AW and W are captured independently into holding registers, in either order or in the same cycle.
- s_aw_ready = !aw_held & !s_b_valid; s_w_ready = !w_held & !s_b_valid.
- Only one write is in flight at a time.

Read path:
- Only one read is in flight at a time; s_ar_ready = !s_r_valid.
- Read data is sampled on the AR handshake cycle.

## Timing
- Reset values:
  - All ready and valid outputs are 0; s_b_resp and s_r_resp are 00; s_r_data is 0.
  - All config outputs are 0; imp_start, imp_busy and irq are 0; CTRL and DONE are 0.
  - The ready outputs go to 1 in the first cycle after rst deasserts.
- rst asserted mid-transaction clears the holding registers and any pending response. The dropped response is never issued.
- Write, cycle N: the last of AW/W is handshaked.
- Write, cycle N+1:
  - The register is updated and visible on its output.
  - s_b_valid=1 with the response code.
  - imp_start=1 if START was accepted, and imp_busy=1.
- s_b_valid holds until s_b_ready. The holding registers are freed in the same cycle, so the next AW/W handshake can occur in the cycle after the B handshake.
- Read: AR handshake in cycle N gives s_r_valid=1 in cycle N+1.
  - s_r_data and s_r_resp stay stable until s_r_ready.
  - A read in the same cycle as a write commit returns the pre-commit value.
- imp_start is high for exactly one cycle.
- irq is registered: it rises 1 cycle after DONE or IRQ_EN becomes 1.
- Reads and writes are independent and may complete in the same cycle.

## Test plan
- Reset, then read 0x24 -> r_data=32'h494D_5001, r_resp=00. Read 0x04 -> 0.
- Write 0x18 with data 32'hAABBCCDD and strb 4'b0101, after a prior value of 0 -> imp_src_baddr=32'h00BB00DD. Read back gives the same value.
- Present W two cycles before AW for HSIZE=4 -> b_valid exactly 1 cycle after the AW handshake. imp_hsize=4. b_ready held low for 3 cycles keeps b_valid=1 and keeps aw_ready/w_ready low.
- Write CTRL=32'h3 -> one-cycle imp_start, imp_busy=1. A second START while busy gives no pulse. Pulse imp_done -> busy=0, DONE=1, irq=1 one cycle later. W1C 0x04 with 32'h2 -> DONE=0, irq=0.
- W1C of DONE in the same cycle as imp_done -> DONE stays 1.
- Read 0x30 and write 0x2C -> resp 2'b10, read data 0, no register changes.
